// File: rtl/wta_result_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wta_result_collector_pkg
// Brief    : Shared constants and record-layout helpers for the WTA result
//            collector: default widths, result FIFO depth and the packed
//            record field offsets {period_idx, neuron, spike_time}.
// Revision : 1.0 - initial release
// ============================================================================
package wta_result_collector_pkg;

  // Default widths match the spiking layer build
  localparam int DEF_NEURON_W      = 4;
  localparam int DEF_TIME_W        = 4;
  localparam int DEF_IDX_W         = 16;
  localparam int DEF_TIME_PERIOD   = 16;
  localparam int DEF_NUM_NEURONS   = 8;
  localparam int RESULT_FIFO_DEPTH = 8;

  // Record layout, LSB first: spike_time, neuron, period_idx
  function automatic int rec_spike_lsb();
    return 0;
  endfunction

  function automatic int rec_neuron_lsb(input int time_w);
    return time_w;
  endfunction

  function automatic int rec_idx_lsb(input int neuron_w, input int time_w);
    return time_w + neuron_w;
  endfunction

  function automatic int rec_width(input int idx_w, input int neuron_w, input int time_w);
    return idx_w + neuron_w + time_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wta_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : wta_result_collector_if
// Brief    : Valid/ready result stream from the collector to readout logic.
//            master = collector side, slave = consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface wta_result_collector_if
  import wta_result_collector_pkg::*;
#(
  parameter int NEURON_W = DEF_NEURON_W,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int IDX_W    = DEF_IDX_W
);

  logic                out_valid;
  logic                out_ready;
  logic [NEURON_W-1:0] out_neuron;
  logic [TIME_W-1:0]   out_spike_time;
  logic                out_no_spike;
  logic [IDX_W-1:0]    out_period_idx;

  modport master (
    output out_valid,
    output out_neuron,
    output out_spike_time,
    output out_no_spike,
    output out_period_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_neuron,
    input  out_spike_time,
    input  out_no_spike,
    input  out_period_idx,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/wta_result_collector_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wta_result_collector_sync_fifo
// Brief    : Generic synchronous first-word-fall-through FIFO. The head entry
//            is always visible on rdata; a push while full is accepted only
//            when a pop happens on the same edge. DEPTH must be a power of
//            two (>= 2) so the pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module wta_result_collector_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_l,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         wdata,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  // A pop on an empty FIFO is ignored; a full FIFO accepts a push only
  // when it is being popped on the same edge
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage write; cleared on reset so the head reads zero when empty
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and exact occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wta_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : wta_result_collector
// Brief    : Samples the spiking layer's winner and spike time at the last
//            time step of each period, tags it with a period index and
//            buffers it in a FWFT FIFO presented as a valid/ready stream.
//            Captures arriving while the FIFO is full (and not being popped)
//            are dropped and counted (saturating at 255).
//            Optional feature macro: WTA_WIN_HIST_EN - per-neuron saturating
//            win histogram read through hist_sel/hist_count.
// Revision : 1.0 - initial release
// ============================================================================
module wta_result_collector
  import wta_result_collector_pkg::*;
#(
  parameter int NEURON_W    = DEF_NEURON_W,
  parameter int TIME_W      = DEF_TIME_W,
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  parameter int DEPTH       = RESULT_FIFO_DEPTH,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS
) (
  input  wire logic                   clk,
  input  wire logic                   rst_l,
  input  wire logic [TIME_W-1:0]      time_val,
  input  wire logic [NEURON_W-1:0]    winning_neuron,
  input  wire logic [TIME_W-1:0]      output_spike_time,
  wta_result_collector_if.master      out_if,
  output logic      [$clog2(DEPTH):0] fifo_count,
  output logic      [7:0]             drop_cnt,
  input  wire logic [NEURON_W-1:0]    hist_sel,
  input  wire logic                   hist_clr,
  output logic      [7:0]             hist_count
);

  localparam int                REC_W      = rec_width(IDX_W, NEURON_W, TIME_W);
  localparam int                SPIKE_LSB  = rec_spike_lsb();
  localparam int                NEURON_LSB = rec_neuron_lsb(TIME_W);
  localparam int                IDX_LSB    = rec_idx_lsb(NEURON_W, TIME_W);
  localparam logic [TIME_W-1:0] CAP_TIME   = TIME_W'(TIME_PERIOD - 1);
  localparam logic [TIME_W-1:0] NO_SPIKE   = {TIME_W{1'b1}};

  logic [IDX_W-1:0] r_period_idx;
  logic [7:0]       r_drop_cnt;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;
  logic             w_capture;
  logic             w_full;
  logic             w_empty;

  // Only the last step of the period captures; out-of-range time never matches
  assign w_capture = (time_val == CAP_TIME);
  assign w_rec     = {r_period_idx, winning_neuron, output_spike_time};

  wta_result_collector_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (w_capture),
    .wdata (w_rec),
    .pop   (out_if.out_ready),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign out_if.out_valid      = !w_empty;
  assign out_if.out_spike_time = w_head[SPIKE_LSB  +: TIME_W];
  assign out_if.out_neuron     = w_head[NEURON_LSB +: NEURON_W];
  assign out_if.out_period_idx = w_head[IDX_LSB    +: IDX_W];
  assign out_if.out_no_spike   = (out_if.out_spike_time == NO_SPIKE);
  assign drop_cnt              = r_drop_cnt;

  // Period index advances on every capture, dropped or not; drops saturate
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_period_idx <= '0;
      r_drop_cnt   <= '0;
    end else if (w_capture) begin
      r_period_idx <= r_period_idx + 1'b1;
      // Full implies non-empty, so out_ready alone means a pop frees a slot
      if (w_full && !out_if.out_ready && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

`ifdef WTA_WIN_HIST_EN
  logic [7:0] r_hist [NUM_NEURONS];

  // Win histogram: clear wins over increment; no-spike periods are not wins
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_hist[i] <= '0;
    end else if (hist_clr) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_hist[i] <= '0;
    end else if (w_capture && (output_spike_time != NO_SPIKE)) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if ((32'(winning_neuron) == i) && (r_hist[i] != 8'hFF))
          r_hist[i] <= r_hist[i] + 1'b1;
      end
    end
  end

  // Histogram read mux; out-of-range selects read as zero
  always_comb begin
    hist_count = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (32'(hist_sel) == i) hist_count = r_hist[i];
    end
  end
`else
  logic unused_hist;

  assign unused_hist = ^{hist_sel, hist_clr};
  assign hist_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wta_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_wta_result_collector
// Brief    : Directed self-checking bench for wta_result_collector.
//            Histogram checks follow WTA_WIN_HIST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wta_result_collector;

  logic       clk;
  logic       rst_l;
  logic [3:0] time_val;
  logic [3:0] winning_neuron;
  logic [3:0] output_spike_time;
  logic [3:0] fifo_count;
  logic [7:0] drop_cnt;
  logic [3:0] hist_sel;
  logic       hist_clr;
  logic [7:0] hist_count;

  int total = 0;
  int bad   = 0;

  wta_result_collector_if #(.NEURON_W(4), .TIME_W(4), .IDX_W(16)) out_if ();

  wta_result_collector #(
    .NEURON_W    (4),
    .TIME_W      (4),
    .TIME_PERIOD (16),
    .DEPTH       (8),
    .IDX_W       (16),
    .NUM_NEURONS (8)
  ) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .time_val          (time_val),
    .winning_neuron    (winning_neuron),
    .output_spike_time (output_spike_time),
    .out_if            (out_if),
    .fifo_count        (fifo_count),
    .drop_cnt          (drop_cnt),
    .hist_sel          (hist_sel),
    .hist_clr          (hist_clr),
    .hist_count        (hist_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full period; the final tick is the capture edge
  task automatic run_period(input int nr, input int st);
    for (int t = 0; t < 16; t++) begin
      time_val          = 4'(t);
      winning_neuron    = 4'(nr);
      output_spike_time = 4'(st);
      tick();
    end
    time_val = 4'd0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #2;
    rst_l = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    #2;
    rst_l = 1'b1;
  endtask

  int nrs [3] = '{2, 5, 7};
  int sts [3] = '{3, 9, 15};
  int exp_pop;
  int held_idx;
  int held_n;
  logic stall;

  initial begin
    rst_l             = 1'b0;
    time_val          = 4'd0;
    winning_neuron    = 4'd0;
    output_spike_time = 4'd0;
    hist_sel          = 4'd0;
    hist_clr          = 1'b0;
    out_if.out_ready  = 1'b0;
    tick();
    tick();

    // ---------------- reset state
    chk("rst_valid", out_if.out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_idx", out_if.out_period_idx, 0);
    chk("rst_neuron", out_if.out_neuron, 0);
    chk("rst_hist", hist_count, 0);
    rst_l = 1'b1;

    // ---------------- three periods, consumer always ready
    out_if.out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 15; t++) begin
        time_val          = 4'(t);
        winning_neuron    = 4'(nrs[p]);
        output_spike_time = 4'(sts[p]);
        tick();
      end
      chk("t1_pre_valid", out_if.out_valid, 0);
      time_val = 4'd15;
      tick();
      time_val = 4'd0;
      chk("t1_valid", out_if.out_valid, 1);
      chk("t1_idx", out_if.out_period_idx, p);
      chk("t1_neuron", out_if.out_neuron, nrs[p]);
      chk("t1_spike", out_if.out_spike_time, sts[p]);
      chk("t1_nospike", out_if.out_no_spike, (p == 2) ? 1 : 0);
    end
    tick();
    chk("t1_drained", out_if.out_valid, 0);

    // ---------------- stalled consumer for 10 periods
    async_reset();
    release_reset();
    out_if.out_ready = 1'b0;
    for (int p = 0; p < 10; p++) run_period(p % 8, p % 15);
    chk("t2_full_count", fifo_count, 8);
    chk("t2_drop", drop_cnt, 2);
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", out_if.out_valid, 1);
      chk("t2_drain_idx", out_if.out_period_idx, i);
      chk("t2_drain_neuron", out_if.out_neuron, i % 8);
      tick();
    end
    chk("t2_empty_valid", out_if.out_valid, 0);
    chk("t2_empty_count", fifo_count, 0);
    out_if.out_ready = 1'b0;
    run_period(10 % 8, 10 % 15);
    chk("t2_next_idx", out_if.out_period_idx, 10);
    chk("t2_next_neuron", out_if.out_neuron, 2);
    chk("t2_next_spike", out_if.out_spike_time, 10);
    chk("t2_next_count", fifo_count, 1);

    // ---------------- full FIFO: capture and pop on the same edge
    for (int p = 11; p < 18; p++) run_period(p % 8, p % 15);
    chk("t3_full_count", fifo_count, 8);
    chk("t3_drop_before", drop_cnt, 2);
    for (int t = 0; t < 15; t++) begin
      time_val = 4'(t);
      tick();
    end
    time_val          = 4'd15;
    winning_neuron    = 4'(18 % 8);
    output_spike_time = 4'(18 % 15);
    out_if.out_ready  = 1'b1;
    tick();
    out_if.out_ready  = 1'b0;
    time_val          = 4'd0;
    chk("t3_count_kept", fifo_count, 8);
    chk("t3_drop_kept", drop_cnt, 2);
    chk("t3_head_idx", out_if.out_period_idx, 11);
    out_if.out_ready = 1'b1;
    for (int i = 11; i < 19; i++) begin
      chk("t3_drain_idx", out_if.out_period_idx, i);
      chk("t3_drain_neuron", out_if.out_neuron, i % 8);
      chk("t3_drain_spike", out_if.out_spike_time, i % 15);
      tick();
    end
    chk("t3_empty", out_if.out_valid, 0);

    // ---------------- asynchronous reset with records buffered
    out_if.out_ready = 1'b0;
    for (int p = 0; p < 4; p++) run_period(p, p + 1);
    chk("t4_count_before", fifo_count, 4);
    chk("t4_drop_before", drop_cnt, 2);
    async_reset();
    chk("t4_rst_valid", out_if.out_valid, 0);
    chk("t4_rst_count", fifo_count, 0);
    chk("t4_rst_drop", drop_cnt, 0);
    release_reset();
    run_period(4, 6);
    chk("t4_idx0", out_if.out_period_idx, 0);
    chk("t4_neuron", out_if.out_neuron, 4);
    chk("t4_spike", out_if.out_spike_time, 6);
    out_if.out_ready = 1'b1;
    tick();
    chk("t4_popped", out_if.out_valid, 0);

    // ---------------- toggling ready with back-to-back captures
    async_reset();
    release_reset();
    exp_pop = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 12) begin
        time_val          = 4'd15;
        winning_neuron    = 4'(cyc % 8);
        output_spike_time = 4'(cyc % 15);
      end else begin
        time_val = 4'd0;
      end
      out_if.out_ready = (cyc % 2) == 1;
      if (out_if.out_valid && out_if.out_ready) begin
        chk("t6_pop_idx", out_if.out_period_idx, exp_pop);
        chk("t6_pop_neuron", out_if.out_neuron, exp_pop % 8);
        chk("t6_pop_spike", out_if.out_spike_time, exp_pop % 15);
        exp_pop++;
      end
      stall    = out_if.out_valid && !out_if.out_ready;
      held_idx = int'(out_if.out_period_idx);
      held_n   = int'(out_if.out_neuron);
      tick();
      if (stall) begin
        chk("t6_hold_idx", out_if.out_period_idx, held_idx);
        chk("t6_hold_neuron", out_if.out_neuron, held_n);
      end
    end
    chk("t6_pop_total", exp_pop, 12);
    chk("t6_empty", out_if.out_valid, 0);
    chk("t6_drop", drop_cnt, 0);

    // ---------------- saturation: 300 wins for neuron 3, then a no-spike capture
    async_reset();
    release_reset();
    out_if.out_ready  = 1'b0;
    time_val          = 4'd15;
    winning_neuron    = 4'd3;
    output_spike_time = 4'd2;
    repeat (300) tick();
    winning_neuron    = 4'd0;
    output_spike_time = 4'd15;
    tick();
    time_val = 4'd0;
    chk("t5_drop_sat", drop_cnt, 255);
    chk("t5_count", fifo_count, 8);
`ifdef WTA_WIN_HIST_EN
    hist_sel = 4'd3;
    #1;
    chk("t5_hist3_sat", hist_count, 255);
    hist_sel = 4'd0;
    #1;
    chk("t5_hist0_nospike", hist_count, 0);
    hist_sel = 4'd9;
    #1;
    chk("t5_hist_oob", hist_count, 0);
    hist_sel = 4'd3;
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    chk("t5_hist_clr", hist_count, 0);
`else
    hist_sel = 4'd3;
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    chk("t5_hist_off", hist_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
